tpu_tile_scheduler: RTL and testbench

- Sequences the 8x8 TPU over a full m x n x k matrix multiply by splitting the output into TILE x TILE tiles.
- For each tile it streams k operand words from GBUFF_A/GBUFF_B into the TPU, then drains TILE result rows into GBUFF_OUT.
- Sits between the top-level control (in_valid, m, n, k, out_valid) and the existing tpu and global_buffer instances.
- Replaces the fixed 32-word RD/WR sequencing with dimension-aware scheduling.

---
 rtl/tpu_tile_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_tpu_tile_scheduler.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_tile_scheduler.sv
// Tile scheduler for the 8x8 TPU: walks an m x n x k matmul one TILE x TILE output
// tile at a time, streaming operands from GBUFF_A/B and draining result rows to GBUFF_OUT.
module tpu_tile_scheduler #(
    parameter int unsigned TILE   = 8,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DIM_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DIM_W-1:0]  m,
    input  logic [DIM_W-1:0]  n,
    input  logic [DIM_W-1:0]  k,
    output logic              busy,
    output logic              out_valid,
    output logic [ADDR_W-1:0] gbuf_idx_a,
    output logic [ADDR_W-1:0] gbuf_idx_b,
    output logic              tpu_clear,
    output logic              tpu_in_valid,
    input  logic              tpu_in_ready,
    input  logic              tpu_out_valid,
    output logic              tpu_out_ready,
    output logic              gbuf_wr_en_o,
    output logic [ADDR_W-1:0] gbuf_idx_o
);
    localparam int unsigned SHIFT = $clog2(TILE);
    localparam int unsigned ROW_W = (SHIFT > 0) ? SHIFT : 1;
    localparam int unsigned EXT_W = DIM_W + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_LOAD  = 3'd2,
        S_WAIT  = 3'd3,
        S_DRAIN = 3'd4,
        S_NEXT  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [DIM_W-1:0]  k_l;
    logic [DIM_W-1:0]  mt_l;
    logic [DIM_W-1:0]  nt_l;
    logic [DIM_W-1:0]  mi_q;
    logic [DIM_W-1:0]  ni_q;
    logic [DIM_W-1:0]  kk_q;
    logic [ROW_W-1:0]  r_q;

    logic [EXT_W-1:0]  mt_ext_c;
    logic [EXT_W-1:0]  nt_ext_c;
    logic              dims_zero_c;
    logic              last_k_c;
    logic              last_row_c;
    logic              last_ni_c;
    logic              last_mi_c;
    logic              accept_c;
    logic              load_hs_c;
    logic              row_wr_c;
    logic [ADDR_W-1:0] addr_a_c;
    logic [ADDR_W-1:0] addr_b_c;
    logic [ADDR_W-1:0] addr_o_c;

    // Tile counts: ceil(dim / TILE), evaluated on the raw inputs at accept time
    assign mt_ext_c    = (EXT_W'(m) + EXT_W'(TILE - 1)) >> SHIFT;
    assign nt_ext_c    = (EXT_W'(n) + EXT_W'(TILE - 1)) >> SHIFT;
    assign dims_zero_c = (m == '0) || (n == '0) || (k == '0);

    assign accept_c   = (state_q == S_IDLE) && in_valid;
    assign load_hs_c  = (state_q == S_LOAD) && tpu_in_ready;
    assign row_wr_c   = ((state_q == S_WAIT) || (state_q == S_DRAIN)) && tpu_out_valid;
    assign last_k_c   = (kk_q == k_l - DIM_W'(1));
    assign last_row_c = (r_q == ROW_W'(TILE - 1));
    assign last_ni_c  = (ni_q == nt_l - DIM_W'(1));
    assign last_mi_c  = (mi_q == mt_l - DIM_W'(1));

    // Buffer indices; all arithmetic is carried at ADDR_W and wraps there
    assign addr_a_c = ADDR_W'(mi_q) * ADDR_W'(k_l) + ADDR_W'(kk_q);
    assign addr_b_c = ADDR_W'(ni_q) * ADDR_W'(k_l) + ADDR_W'(kk_q);
    assign addr_o_c = (ADDR_W'(mi_q) * ADDR_W'(nt_l) + ADDR_W'(ni_q)) * ADDR_W'(TILE)
                    + ADDR_W'(r_q);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = dims_zero_c ? S_DONE : S_CLR;
                end
            end
            S_CLR:   state_d = S_LOAD;
            S_LOAD: begin
                if (tpu_in_ready && last_k_c) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (tpu_out_valid) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (tpu_out_valid && last_row_c) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                state_d = (last_ni_c && last_mi_c) ? S_DONE : S_CLR;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode; buffer reads are combinational so indices track the state directly
    always_comb begin
        tpu_clear     = 1'b0;
        tpu_in_valid  = 1'b0;
        tpu_out_ready = 1'b0;
        gbuf_wr_en_o  = 1'b0;
        gbuf_idx_a    = '0;
        gbuf_idx_b    = '0;
        gbuf_idx_o    = '0;
        case (state_q)
            S_CLR: begin
                tpu_clear = 1'b1;
            end
            S_LOAD: begin
                tpu_in_valid = 1'b1;
                gbuf_idx_a   = addr_a_c;
                gbuf_idx_b   = addr_b_c;
            end
            S_WAIT, S_DRAIN: begin
                tpu_out_ready = 1'b1;
                gbuf_wr_en_o  = tpu_out_valid;
                gbuf_idx_o    = tpu_out_valid ? addr_o_c : '0;
            end
            default: ;
        endcase
    end

    // Latched job dimensions and tile / operand / row counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_l  <= '0;
            mt_l <= '0;
            nt_l <= '0;
            mi_q <= '0;
            ni_q <= '0;
            kk_q <= '0;
            r_q  <= '0;
        end else begin
            if (accept_c) begin
                k_l  <= k;
                mt_l <= DIM_W'(mt_ext_c);
                nt_l <= DIM_W'(nt_ext_c);
                mi_q <= '0;
                ni_q <= '0;
                kk_q <= '0;
                r_q  <= '0;
            end
            if (state_q == S_CLR) begin
                kk_q <= '0;
                r_q  <= '0;
            end
            if (load_hs_c) begin
                kk_q <= kk_q + DIM_W'(1);
            end
            if (row_wr_c) begin
                r_q <= r_q + ROW_W'(1);
            end
            if (state_q == S_NEXT) begin
                if (!last_ni_c) begin
                    ni_q <= ni_q + DIM_W'(1);
                end else if (!last_mi_c) begin
                    ni_q <= '0;
                    mi_q <= mi_q + DIM_W'(1);
                end
            end
        end
    end

    // Job status: busy spans accept..DONE, completion pulse lands the cycle after DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= (state_q == S_DONE);
            if (accept_c) begin
                busy <= 1'b1;
            end else if (state_q == S_DONE) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tpu_tile_scheduler.sv
// Bench for tpu_tile_scheduler: a queue model of the expected operand reads and row
// writes per job, a simple TPU responder, and a per-cycle checker on the falling edge.
module tb_tpu_tile_scheduler;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DIM_W  = 5;
    localparam int          LAT    = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [DIM_W-1:0]  m = '0;
    logic [DIM_W-1:0]  n = '0;
    logic [DIM_W-1:0]  k = '0;
    logic              busy;
    logic              out_valid;
    logic [ADDR_W-1:0] gbuf_idx_a;
    logic [ADDR_W-1:0] gbuf_idx_b;
    logic              tpu_clear;
    logic              tpu_in_valid;
    logic              tpu_in_ready = 1'b1;
    logic              tpu_out_valid = 1'b0;
    logic              tpu_out_ready;
    logic              gbuf_wr_en_o;
    logic [ADDR_W-1:0] gbuf_idx_o;

    tpu_tile_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .m             (m),
        .n             (n),
        .k             (k),
        .busy          (busy),
        .out_valid     (out_valid),
        .gbuf_idx_a    (gbuf_idx_a),
        .gbuf_idx_b    (gbuf_idx_b),
        .tpu_clear     (tpu_clear),
        .tpu_in_valid  (tpu_in_valid),
        .tpu_in_ready  (tpu_in_ready),
        .tpu_out_valid (tpu_out_valid),
        .tpu_out_ready (tpu_out_ready),
        .gbuf_wr_en_o  (gbuf_wr_en_o),
        .gbuf_idx_o    (gbuf_idx_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int exp_a[$];
    int exp_b[$];
    int exp_o[$];
    int exp_tiles = 0;
    int exp_hs = 0;
    int exp_wr = 0;
    int n_clear = 0;
    int n_wr = 0;
    int n_hs = 0;
    int n_ov = 0;
    int t_in = 0;
    int t_clr = -1;
    int t_ov = -1;
    bit checking = 1'b0;
    int in_mode = 0;
    int out_mode = 0;
    int pat_i = 0;
    int wait_cnt = 0;
    bit in_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected read/write sequences from the tiling rules, tile order mi-major
    task automatic build_model(input int jm, input int jn, input int jk);
        int mt;
        int nt;
        exp_a.delete();
        exp_b.delete();
        exp_o.delete();
        mt = (jm + 7) / 8;
        nt = (jn + 7) / 8;
        exp_tiles = (jm == 0 || jn == 0 || jk == 0) ? 0 : mt * nt;
        if (exp_tiles > 0) begin
            for (int mi = 0; mi < mt; mi++) begin
                for (int ni = 0; ni < nt; ni++) begin
                    for (int kk = 0; kk < jk; kk++) begin
                        exp_a.push_back(mi * jk + kk);
                        exp_b.push_back(ni * jk + kk);
                    end
                    for (int r = 0; r < 8; r++) exp_o.push_back((mi * nt + ni) * 8 + r);
                end
            end
        end
        exp_hs = exp_a.size();
        exp_wr = exp_o.size();
        n_clear = 0; n_wr = 0; n_hs = 0; n_ov = 0;
        t_clr = -1; t_ov = -1;
    endtask

    task automatic issue(input int jm, input int jn, input int jk, input int im, input int om);
        in_mode  = im;
        out_mode = om;
        checking = 1'b1;
        @(posedge clk); #1;
        m = DIM_W'(jm); n = DIM_W'(jn); k = DIM_W'(jk);
        in_valid = 1'b1;
        t_in = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic finish_job(input string tag);
        for (int i = 0; i < 4000 && n_ov == 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        check({tag, "_out_valid_count"}, n_ov, 1);
        check({tag, "_clear_count"}, n_clear, exp_tiles);
        check({tag, "_handshakes"}, n_hs, exp_hs);
        check({tag, "_writes"}, n_wr, exp_wr);
        check({tag, "_reads_left"}, exp_a.size(), 0);
        check({tag, "_writes_left"}, exp_o.size(), 0);
    endtask

    // TPU responder: ready pattern on operands, rows appear LAT cycles into the wait
    initial begin
        forever begin
            @(posedge clk); #1;
            pat_i++;
            tpu_in_ready = (in_mode == 0) ? 1'b1 : in_pat[pat_i % 4];
            if (tpu_out_ready) wait_cnt++;
            else wait_cnt = 0;
            tpu_out_valid = tpu_out_ready && (wait_cnt > LAT) &&
                            (out_mode == 0 || (wait_cnt % 3) != 0);
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            if (tpu_in_valid) begin
                if (exp_a.size() == 0) begin
                    check("unexpected_read", 1, 0);
                end else begin
                    check("idx_a", int'(gbuf_idx_a), exp_a[0]);
                    check("idx_b", int'(gbuf_idx_b), exp_b[0]);
                    if (tpu_in_ready) begin
                        void'(exp_a.pop_front());
                        void'(exp_b.pop_front());
                        n_hs++;
                    end
                end
                check("busy_in_load", int'(busy), 1);
            end else begin
                check("idx_a_idle", int'(gbuf_idx_a), 0);
                check("idx_b_idle", int'(gbuf_idx_b), 0);
            end
            if (gbuf_wr_en_o) begin
                if (exp_o.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    check("idx_o", int'(gbuf_idx_o), exp_o[0]);
                    void'(exp_o.pop_front());
                    n_wr++;
                end
                check("wr_needs_valid", int'(tpu_out_valid), 1);
            end else begin
                check("idx_o_idle", int'(gbuf_idx_o), 0);
            end
            if (tpu_out_ready) check("busy_in_drain", int'(busy), 1);
            if (tpu_clear) begin
                n_clear++;
                if (t_clr < 0) t_clr = cyc;
                check("clear_exclusive", int'(tpu_in_valid | tpu_out_ready), 0);
            end
            if (out_valid) begin
                n_ov++;
                t_ov = cyc;
                check("busy_after_done", int'(busy), 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_clear", int'(tpu_clear), 0);
        check("rst_in_valid", int'(tpu_in_valid), 0);
        check("rst_out_ready", int'(tpu_out_ready), 0);
        check("rst_wr_en", int'(gbuf_wr_en_o), 0);
        check("rst_idx_a", int'(gbuf_idx_a), 0);
        check("rst_idx_o", int'(gbuf_idx_o), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single full tile
        build_model(8, 8, 8);
        check("pin_888_reads", exp_a.size(), 8);
        check("pin_888_last_a", exp_a[7], 7);
        check("pin_888_last_o", exp_o[7], 7);
        issue(8, 8, 8, 0, 0);
        finish_job("j888");
        check("j888_clear_latency", t_clr - t_in, 1);
        check("j888_clears", n_clear, 1);
        check("j888_writes_lit", n_wr, 8);

        // 2 x 3 tiles, with an in_valid glitch mid-job that must be ignored
        build_model(16, 24, 4);
        check("pin_6t_reads", exp_a.size(), 24);
        check("pin_6t_a_first_t12", exp_a[20], 4);
        check("pin_6t_a_last_t12", exp_a[23], 7);
        check("pin_6t_b_first_t12", exp_b[20], 8);
        check("pin_6t_b_last_t12", exp_b[23], 11);
        check("pin_6t_o_first_t12", exp_o[40], 40);
        check("pin_6t_o_last_t12", exp_o[47], 47);
        issue(16, 24, 4, 0, 0);
        for (int i = 0; i < 200 && n_clear < 2; i++) @(posedge clk);
        #1;
        m = 5'd31; n = 5'd31; k = 5'd31; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        finish_job("j6t");
        check("j6t_tiles_lit", n_clear, 6);

        // Partial tile
        build_model(5, 5, 3);
        issue(5, 5, 3, 0, 0);
        finish_job("j553");
        check("j553_hs_lit", n_hs, 3);
        check("j553_wr_lit", n_wr, 8);

        // Degenerate k=0
        build_model(8, 8, 0);
        issue(8, 8, 0, 0, 0);
        finish_job("jk0");
        check("jk0_done_latency", t_ov - t_in, 2);
        check("jk0_no_clear", n_clear, 0);

        // Backpressure on both sides
        build_model(16, 16, 8);
        issue(16, 16, 8, 1, 1);
        finish_job("jbp");
        check("jbp_writes_lit", n_wr, 32);

        // Reset during the drain of tile 2 of a 4-tile job
        build_model(16, 16, 8);
        issue(16, 16, 8, 0, 1);
        for (int i = 0; i < 2000 && n_wr < 11; i++) @(posedge clk);
        check("abort_reached_drain", int'(n_wr >= 11 && n_clear == 2), 1);
        #2;
        rst_n = 1'b0;
        checking = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_out_ready", int'(tpu_out_ready), 0);
        check("abort_wr_en", int'(gbuf_wr_en_o), 0);
        check("abort_idx_o", int'(gbuf_idx_o), 0);
        check("abort_in_valid", int'(tpu_in_valid), 0);
        check("abort_clear", int'(tpu_clear), 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        build_model(0, 0, 0);
        checking = 1'b1;
        repeat (20) @(posedge clk);
        check("abort_no_out_valid", n_ov, 0);
        check("abort_no_clear", n_clear, 0);

        build_model(8, 8, 8);
        issue(8, 8, 8, 0, 0);
        finish_job("jpost");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
